// File: rtl/conv2_stream_ctrl.sv
// Sequencer for the second convolution layer: streams one pooled feature map into
// the conv layer, stores every valid result window and reports done or err.
module conv2_stream_ctrl #(
  parameter int IMG_W   = 14,
  parameter int IMG_H   = 14,
  parameter int K       = 5,
  parameter int AW      = 8,
  parameter int OW      = 7,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [95:0]   fm_data,
  output logic          conv_clear,
  output logic          conv_valid,
  output logic [95:0]   conv_image,
  input  logic          conv_finish,
  input  logic          conv_invalid,
  output logic          wr_en,
  output logic [OW-1:0] wr_addr
);
  localparam int N   = IMG_W * IMG_H;
  localparam int M   = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int WCW = $clog2(M + 1);
  localparam int DCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  rd_cnt;
  logic [WCW-1:0] wr_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           valid_q;
  logic           wr_try;
  logic           rd_last, wr_full, drain_expired;

  assign rd_last       = (rd_cnt == AW'(N - 1));
  assign wr_full       = (wr_cnt == WCW'(M));
  assign drain_expired = (drain_cnt == DCW'(TIMEOUT - 1));

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    conv_clear = 1'b0;
    rd_en      = 1'b0;
    done       = 1'b0;
    wr_try     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        conv_clear = 1'b1;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        rd_en  = 1'b1;
        wr_try = !conv_invalid && !conv_finish;
        if (rd_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        wr_try = !conv_invalid && !conv_finish;
        if (conv_finish || drain_expired) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = !err;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    // Abort outranks everything and silences the strobes in the same cycle.
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      rd_en     = 1'b0;
      wr_try    = 1'b0;
      done      = 1'b0;
    end
  end

  assign rd_addr    = rd_cnt;
  assign wr_en      = wr_try && !wr_full;
  assign wr_addr    = OW'(wr_cnt);
  assign conv_valid = valid_q && !abort;
  assign conv_image = fm_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      drain_cnt <= '0;
      valid_q   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= rd_en;
      if (state == S_IDLE && start) err <= 1'b0;
      if (state == S_CLEAR) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (rd_en && !rd_last) rd_cnt <= rd_cnt + 1'b1;
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (wr_try && wr_full) err <= 1'b1;
      if (state == S_DRAIN) begin
        if (!drain_expired) drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
      // Finish is judged before timeout; a short window count is an error too.
      if (state == S_DRAIN && !abort) begin
        if (conv_finish) begin
          if (!wr_full) err <= 1'b1;
        end else if (drain_expired) begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule
